// File: rtl/adc_gen_pkg.sv
// Shared types and constants for the ADC pattern generator.
//   mode_e       : pattern selector (CONST/RAMP/TOGGLE/PRBS)
//   state_e      : run-control FSM states (IDLE/RUN/FIN)
//   PRBS16_TAPS  : feedback taps of x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   PRBS16_SEED  : default LFSR seed
//   prbs16_next  : one Fibonacci step, shift left, feedback bit enters at LSB
package adc_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_PRBS   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [15:0] PRBS16_TAPS = 16'hB400;
    localparam logic [15:0] PRBS16_SEED = 16'hACE1;

    function automatic logic [15:0] prbs16_next(input logic [15:0] s);
        return {s[14:0], ^(s & PRBS16_TAPS)};
    endfunction

endpackage

// File: rtl/adc_lfsr16.sv
// 16-bit Fibonacci PRBS register.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, state returns to SEED
//   load    : load 'seed' (has priority over advance)
//   seed    : value loaded on 'load'
//   advance : step the LFSR once
//   state   : current LFSR state
module adc_lfsr16
    import adc_gen_pkg::*;
#(
    parameter logic [15:0] SEED = PRBS16_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEED;
        end else if (load) begin
            state_reg <= seed;
        end else if (advance) begin
            state_reg <= prbs16_next(state_reg);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-lane ADC sample source (CONST / RAMP / TOGGLE / PRBS patterns).
//   clk, rst       : clock and synchronous active-high reset
//   cfg_mode       : pattern mode, latched on accepted start
//   cfg_const      : constant / ramp base / toggle value, latched on start
//   cfg_step       : per-lane increment (RAMP, PRBS), latched on start
//   cfg_burst_len  : samples per run, 0 = continuous, latched on start
//   start, stop    : run control (start accepted only in IDLE, stop only in RUN)
//   adc_data       : lane i at [i*DATA_W +: DATA_W]
//   adc_valid      : adc_data carries a new sample this cycle
//   busy           : high while running
//   done           : one-cycle pulse after the last sample of a burst
//   sample_cnt     : samples emitted in current/last run, saturating
module adc_pattern_gen
    import adc_gen_pkg::*;
#(
    parameter int          NUM_CH    = 96,
    parameter int          DATA_W    = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode,
    input  logic [DATA_W-1:0]        cfg_const,
    input  logic [DATA_W-1:0]        cfg_step,
    input  logic [15:0]              cfg_burst_len,
    input  logic                     start,
    input  logic                     stop,
    output logic [NUM_CH*DATA_W-1:0] adc_data,
    output logic                     adc_valid,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              sample_cnt
);

    localparam logic [DATA_W-1:0] NUM_CH_W = DATA_W'(NUM_CH);

    state_e                    state_reg;
    mode_e                     mode_reg;
    logic [DATA_W-1:0]         const_reg;
    logic [DATA_W-1:0]         step_reg;
    logic [15:0]               burst_reg;
    logic [DATA_W-1:0]         base_reg;      // lane-0 ramp value of the current sample
    logic                      odd_reg;       // current sample index is odd
    logic [15:0]               burst_cnt_reg; // non-saturating burst comparator count
    logic [15:0]               sample_cnt_reg;
    logic [NUM_CH*DATA_W-1:0]  adc_data_reg;
    logic                      valid_reg;
    logic                      busy_reg;
    logic                      done_reg;

    logic [15:0]               lfsr_state;
    logic                      start_ok;
    logic                      burst_end;
    logic                      run_next;

    mode_e                     gen_mode;
    logic [DATA_W-1:0]         gen_const;
    logic [DATA_W-1:0]         gen_step;
    logic [DATA_W-1:0]         gen_base;
    logic                      gen_odd;
    logic [15:0]               gen_lfsr;
    logic [NUM_CH*DATA_W-1:0]  data_next;

    assign start_ok  = (state_reg == ST_IDLE) && start;
    // Burst end is checked before stop, so a stop on the last sample still yields done.
    assign burst_end = (state_reg == ST_RUN) && (burst_reg != 16'd0) && (burst_cnt_reg == burst_reg);
    assign run_next  = (state_reg == ST_RUN) && !burst_end && !stop;

    // The LFSR register holds the state used by the sample currently on the
    // output; the next sample uses its successor, hence advance-on-emit.
    adc_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .seed    (LFSR_SEED),
        .advance (run_next),
        .state   (lfsr_state)
    );

    // Parameters of the sample about to be emitted: taken straight from the
    // config inputs for sample 0, from the latched/advanced state otherwise.
    always_comb begin
        gen_mode  = mode_reg;
        gen_const = const_reg;
        gen_step  = step_reg;
        gen_base  = base_reg + NUM_CH_W * step_reg;
        gen_odd   = ~odd_reg;
        gen_lfsr  = prbs16_next(lfsr_state);
        if (start_ok) begin
            gen_mode  = mode_e'(cfg_mode);
            gen_const = cfg_const;
            gen_step  = cfg_step;
            gen_base  = cfg_const;
            gen_odd   = 1'b0;
            gen_lfsr  = LFSR_SEED;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            localparam logic [DATA_W-1:0] LANE_IDX = DATA_W'(gi);
            logic [DATA_W-1:0] lane_off;
            logic [DATA_W-1:0] lane_val;

            assign lane_off = LANE_IDX * gen_step;
            assign lane_val = (gen_mode == MODE_CONST)  ? gen_const :
                              (gen_mode == MODE_TOGGLE) ? (gen_odd ? ~gen_const : gen_const) :
                              (gen_mode == MODE_RAMP)   ? gen_base + lane_off :
                                                          gen_lfsr[DATA_W-1:0] + lane_off;
            assign data_next[gi*DATA_W +: DATA_W] = lane_val;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= MODE_CONST;
            const_reg      <= '0;
            step_reg       <= '0;
            burst_reg      <= '0;
            base_reg       <= '0;
            odd_reg        <= 1'b0;
            burst_cnt_reg  <= '0;
            sample_cnt_reg <= '0;
            adc_data_reg   <= '0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    if (start) begin
                        state_reg      <= ST_RUN;
                        mode_reg       <= gen_mode;
                        const_reg      <= cfg_const;
                        step_reg       <= cfg_step;
                        burst_reg      <= cfg_burst_len;
                        base_reg       <= gen_base;
                        odd_reg        <= 1'b0;
                        burst_cnt_reg  <= 16'd1;
                        sample_cnt_reg <= 16'd1;
                        adc_data_reg   <= data_next;
                        valid_reg      <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (burst_end) begin
                        state_reg <= ST_FIN;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (stop) begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else begin
                        base_reg      <= gen_base;
                        odd_reg       <= gen_odd;
                        adc_data_reg  <= data_next;
                        valid_reg     <= 1'b1;
                        burst_cnt_reg <= burst_cnt_reg + 16'd1;
                        if (sample_cnt_reg != 16'hFFFF) begin
                            sample_cnt_reg <= sample_cnt_reg + 16'd1;
                        end
                    end
                end
                ST_FIN: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_data   = adc_data_reg;
    assign adc_valid  = valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Self-checking bench for adc_pattern_gen (4 lanes x 9 bits).
// Expected samples are pushed to a scoreboard queue when a run is started
// and popped by a negedge monitor whenever adc_valid is high.
module tb_adc_pattern_gen;

    localparam int NUM_CH  = 4;
    localparam int DW      = 9;
    localparam int W       = NUM_CH * DW;
    localparam int CAP_MAX = 256;

    typedef logic [W-1:0] word_t;

    typedef struct {
        logic [1:0]  mode;
        logic [8:0]  c;
        logic [8:0]  step;
        logic [15:0] burst;
        logic [15:0] exp_cnt;
        bit          chk_ramp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_mode = 2'd0;
    logic [DW-1:0] cfg_const = '0;
    logic [DW-1:0] cfg_step = '0;
    logic [15:0]   cfg_burst_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    word_t         adc_data;
    logic          adc_valid;
    logic          busy;
    logic          done;
    logic [15:0]   sample_cnt;

    int    total = 0;
    int    bad = 0;
    int    valid_cycles = 0;
    int    done_seen = 0;
    int    cap_n = 0;
    word_t cap [CAP_MAX];
    word_t last_push;
    word_t q[$];
    vec_t  tbl [7];

    adc_pattern_gen #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DW),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_mode      (cfg_mode),
        .cfg_const     (cfg_const),
        .cfg_step      (cfg_step),
        .cfg_burst_len (cfg_burst_len),
        .start         (start),
        .stop          (stop),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .busy          (busy),
        .done          (done),
        .sample_cnt    (sample_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic word_t model(input logic [1:0] mode, input logic [8:0] c,
                                    input logic [8:0] step, input int k,
                                    input logic [15:0] l);
        word_t w;
        w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [8:0] v;
            case (mode)
                2'd0:    v = c;
                2'd1:    v = DW'(int'(c) + (k * NUM_CH + i) * int'(step));
                2'd2:    v = (k % 2 == 1) ? ~c : c;
                default: v = DW'(int'(l[8:0]) + i * int'(step));
            endcase
            w[i*DW +: DW] = v;
        end
        return w;
    endfunction

    task automatic push_run(input logic [1:0] mode, input logic [8:0] c,
                            input logic [8:0] step, input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int k = 0; k < n; k++) begin
            last_push = model(mode, c, step, k, l);
            q.push_back(last_push);
            l = ref_lfsr(l);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        word_t exp_w;
        if (done) done_seen++;
        if (adc_valid) begin
            if (cap_n < CAP_MAX) cap[cap_n] = adc_data;
            cap_n++;
            valid_cycles++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got %h required no sample", adc_data);
            end else begin
                exp_w = q.pop_front();
                if (adc_data !== exp_w) begin
                    bad++;
                    $display("FAIL sb_data[%0d]: got %h required %h", valid_cycles - 1, adc_data, exp_w);
                end
                $display("sample %0d: data=%h", valid_cycles - 1, adc_data);
            end
        end
    end

    task automatic run_burst(input vec_t v);
        bit   found;
        logic prev;
        @(negedge clk);
        cfg_mode      = v.mode;
        cfg_const     = v.c;
        cfg_step      = v.step;
        cfg_burst_len = v.burst;
        valid_cycles  = 0;
        cap_n         = 0;
        done_seen     = 0;
        start         = 1'b1;
        push_run(v.mode, v.c, v.step, int'(v.burst));
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", 64'(adc_valid), 64'd1);
        prev  = adc_valid;
        found = 1'b0;
        for (int n = 0; n < int'(v.burst) + 8 && !found; n++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                chk("done_after_last", 64'(prev), 64'd1);
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("valid_at_done", 64'(adc_valid), 64'd0);
                chk("cnt_at_done", 64'(sample_cnt), 64'(v.exp_cnt));
                chk("valid_cycles", 64'(valid_cycles), 64'(v.exp_cnt));
            end
            prev = adc_valid;
        end
        chk("done_seen", 64'(found), 64'd1);
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        chk("hold_data", 64'(adc_data), 64'(last_push));
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("run mode=%0d c=%h step=%0d burst=%0d valid=%0d cnt=%0d",
                 v.mode, v.c, v.step, v.burst, valid_cycles, sample_cnt);
    endtask

    initial begin
        tbl[0] = '{2'd1, 9'h000, 9'd1, 16'd130, 16'd130, 1'b1};
        tbl[1] = '{2'd2, 9'h0A5, 9'd0, 16'd3,   16'd3,   1'b0};
        tbl[2] = '{2'd3, 9'h000, 9'd0, 16'd4,   16'd4,   1'b0};
        tbl[3] = '{2'd3, 9'h000, 9'd0, 16'd4,   16'd4,   1'b0};
        tbl[4] = '{2'd3, 9'h000, 9'd7, 16'd6,   16'd6,   1'b0};
        tbl[5] = '{2'd1, 9'd500, 9'd3, 16'd5,   16'd5,   1'b0};
        tbl[6] = '{2'd0, 9'h1FF, 9'd0, 16'd1,   16'd1,   1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", 64'(adc_data), 64'd0);
        chk("rst_valid", 64'(adc_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        rst = 1'b0;

        // Table-driven bursts
        for (int t = 0; t < 7; t++) begin
            run_burst(tbl[t]);
            if (tbl[t].chk_ramp) begin
                chk("ramp_s0",   64'(cap[0]),   64'({9'd3, 9'd2, 9'd1, 9'd0}));
                chk("ramp_s1",   64'(cap[1]),   64'({9'd7, 9'd6, 9'd5, 9'd4}));
                chk("ramp_s127", 64'(cap[127]), 64'({9'd511, 9'd510, 9'd509, 9'd508}));
                chk("ramp_s128", 64'(cap[128]), 64'({9'd3, 9'd2, 9'd1, 9'd0}));
            end
        end

        // Continuous CONST, STOP after 1000 samples
        @(negedge clk);
        cfg_mode = 2'd0; cfg_const = 9'h133; cfg_step = 9'd0; cfg_burst_len = 16'd0;
        valid_cycles = 0; done_seen = 0; cap_n = 0;
        start = 1'b1;
        push_run(2'd0, 9'h133, 9'd0, 1000);
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_valid", 64'(adc_valid), 64'd0);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_cnt", 64'(sample_cnt), 64'd1000);
        repeat (5) @(negedge clk);
        chk("stop_no_done", 64'(done_seen), 64'd0);
        chk("stop_valid_cycles", 64'(valid_cycles), 64'd1000);
        chk("stop_sb_empty", 64'(q.size()), 64'd0);

        // Continuous RAMP, ignored START mid-run, RST at sample 50
        @(negedge clk);
        cfg_mode = 2'd1; cfg_const = 9'h010; cfg_step = 9'd2; cfg_burst_len = 16'd0;
        start = 1'b1;
        push_run(2'd1, 9'h010, 9'd2, 51);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1; cfg_mode = 2'd0; cfg_const = 9'h055; cfg_burst_len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_cnt", 64'(sample_cnt), 64'd22);
        chk("ign_start_busy", 64'(busy), 64'd1);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_data", 64'(adc_data), 64'd0);
        chk("midrst_valid", 64'(adc_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_cnt", 64'(sample_cnt), 64'd0);
        chk("midrst_sb_empty", 64'(q.size()), 64'd0);

        // BURST=5 with STOP on the last sample: burst end wins
        @(negedge clk);
        cfg_mode = 2'd0; cfg_const = 9'h012; cfg_step = 9'd0; cfg_burst_len = 16'd5;
        start = 1'b1;
        push_run(2'd0, 9'h012, 9'd0, 5);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stoplast_done", 64'(done), 64'd1);
        chk("stoplast_busy", 64'(busy), 64'd0);
        chk("stoplast_cnt", 64'(sample_cnt), 64'd5);
        @(negedge clk);
        chk("stoplast_done_width", 64'(done), 64'd0);

        // START together with STOP in IDLE: start accepted
        cfg_mode = 2'd2; cfg_const = 9'h0F0; cfg_burst_len = 16'd2;
        start = 1'b1; stop = 1'b1;
        push_run(2'd2, 9'h0F0, 9'd0, 2);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_valid", 64'(adc_valid), 64'd1);
        chk("startstop_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        chk("startstop_done", 64'(done), 64'd1);
        chk("startstop_cnt", 64'(sample_cnt), 64'd2);
        chk("startstop_sb_empty", 64'(q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
